// File: rtl/operand_bram_loader_if.sv
// Word-stream handshake plus the two BRAM write ports of the operand loader.
// master = the loader (consumes the stream, drives BRAM ports); slave = source/BRAM side.
interface operand_bram_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;

   logic              ena_A;
   logic              wea_A;
   logic [ADDR_W-1:0] addra_A;
   logic [DATA_W-1:0] dina_A;

   logic              ena_B;
   logic              wea_B;
   logic [ADDR_W-1:0] addra_B;
   logic [DATA_W-1:0] dina_B;

   modport master (
      input  s_valid, s_data,
      output s_ready,
      output ena_A, wea_A, addra_A, dina_A,
      output ena_B, wea_B, addra_B, dina_B
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready,
      input  ena_A, wea_A, addra_A, dina_A,
      input  ena_B, wea_B, addra_B, dina_B
   );
endinterface

// File: rtl/operand_bram_loader.sv
// Fills operand memories A/B from a word stream: even words go to A[k], odd words to B[k].
// Raises done once DEPTH pairs are stored so the read-side controller can start.
//
// state  | meaning
// IDLE   | waiting for start, stream not accepted
// LOAD_A | next accepted word goes to A[addr]
// LOAD_B | next accepted word goes to B[addr], completes a pair
// DONE   | DEPTH pairs stored, done held until the next start
module operand_bram_loader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   operand_bram_loader_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W:0]      pair_count
);

   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   PAIR_ONE  = 1;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic                ready_q;
   logic                hs;
   logic                last;
   logic                restart;

   logic                ena_a_q;
   logic [ADDR_W-1:0]   addra_a_q;
   logic [DATA_W-1:0]   dina_a_q;
   logic                ena_b_q;
   logic [ADDR_W-1:0]   addra_b_q;
   logic [DATA_W-1:0]   dina_b_q;

   // ready is a flop, so the handshake never depends combinationally on s_valid
   assign hs      = bus.s_valid & ready_q;
   assign last    = (addr == ADDR_LAST);
   assign restart = start & ((state == IDLE) | (state == DONE));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD_A;
         LOAD_A:  if (hs)    state_nxt = LOAD_B;
         LOAD_B:  if (hs)    state_nxt = last ? DONE : LOAD_A;
         DONE:    if (start) state_nxt = LOAD_A;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         ready_q    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pair_count <= '0;
         ena_a_q    <= 1'b0;
         addra_a_q  <= '0;
         dina_a_q   <= '0;
         ena_b_q    <= 1'b0;
         addra_b_q  <= '0;
         dina_b_q   <= '0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == LOAD_A) | (state_nxt == LOAD_B);
         busy    <= (state_nxt == LOAD_A) | (state_nxt == LOAD_B);
         ena_a_q <= 1'b0;
         ena_b_q <= 1'b0;

         if (restart) begin
            addr       <= '0;
            pair_count <= '0;
            done       <= 1'b0;
         end

         if (hs && state == LOAD_A) begin
            ena_a_q   <= 1'b1;
            addra_a_q <= addr;
            dina_a_q  <= bus.s_data;
         end

         // the last pair stops at DEPTH-1 instead of wrapping the address
         if (hs && state == LOAD_B) begin
            ena_b_q    <= 1'b1;
            addra_b_q  <= addr;
            dina_b_q   <= bus.s_data;
            pair_count <= pair_count + PAIR_ONE;
            if (last) done <= 1'b1;
            else      addr <= addr + ADDR_ONE;
         end
      end
   end

   assign bus.s_ready = ready_q;
   assign bus.ena_A   = ena_a_q;
   assign bus.wea_A   = ena_a_q;
   assign bus.addra_A = addra_a_q;
   assign bus.dina_A  = dina_a_q;
   assign bus.ena_B   = ena_b_q;
   assign bus.wea_B   = ena_b_q;
   assign bus.addra_B = addra_b_q;
   assign bus.dina_B  = dina_b_q;

endmodule
